// File: rtl/umni_controle_vaporizador.sv
// UMNI humidifier sequencer: hysteresis demand, minimum on/off times and a
// stepped power ramp advanced once per control tick.
module umni_controle_vaporizador #(
  parameter int unsigned HISTERESE           = 3,
  parameter int unsigned DIV_TICK            = 30,
  parameter int unsigned PASSO_RAMPA         = 10,
  parameter int unsigned TEMPO_MIN_LIGADO    = 8,
  parameter int unsigned TEMPO_MIN_DESLIGADO = 8
) (
  input  logic       clock_geral,
  input  logic       reset,
  input  logic [6:0] umidade_media,
  input  logic       umidade_valida,
  input  logic [6:0] umidadeRef,
  input  logic [6:0] ajuste_de_modo,
  input  logic       botao_on_off,
  output logic [6:0] pot_umidade,
  output logic       umidificador_on_off,
  output logic       umidificador_ligado,
  output logic [2:0] estado,
  output logic       erro
);

  localparam int unsigned TW = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
  localparam logic [7:0] POT_MAX = 8'd100;
  localparam logic [7:0] PASSO   = 8'(PASSO_RAMPA);
  localparam logic [7:0] HIST    = 8'(HISTERESE);
  localparam logic [7:0] MIN_ON  = 8'(TEMPO_MIN_LIGADO);
  localparam logic [7:0] MIN_OFF = 8'(TEMPO_MIN_DESLIGADO);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    SUBINDO  = 3'd1,
    ATIVO    = 3'd2,
    DESCENDO = 3'd3
  } estado_t;

  estado_t       est;
  logic [TW-1:0] cnt_tick;
  logic [2:0]    sinc;
  logic          habilitado;
  logic          demanda;
  logic [7:0]    cont_on;
  logic [7:0]    cont_off;

  logic       tick;
  logic       subida;
  logic       ok;
  logic       fim_demanda;
  logic [7:0] media8;
  logic [7:0] ref8;
  logic [7:0] ajuste8;
  logic [7:0] pot8;
  logic [7:0] alvo;
  logic [7:0] lim_baixo;
  logic [8:0] soma_ref;
  logic [7:0] lim_alto;
  logic [7:0] pot_sobe;
  logic [7:0] pot_desce;
  logic [7:0] pot_aprox;

  // All arithmetic is done 8 bits wide with explicit saturation.
  assign media8    = {1'b0, umidade_media};
  assign ref8      = {1'b0, umidadeRef};
  assign ajuste8   = {1'b0, ajuste_de_modo};
  assign pot8      = {1'b0, pot_umidade};
  assign alvo      = (ajuste8 > POT_MAX) ? POT_MAX : ajuste8;
  assign lim_baixo = (ref8 > HIST) ? (ref8 - HIST) : 8'd0;
  assign soma_ref  = {1'b0, ref8} + {1'b0, HIST};
  assign lim_alto  = (soma_ref > 9'd127) ? 8'd127 : soma_ref[7:0];

  // One ramp step toward the target, never overshooting it.
  assign pot_sobe  = ((alvo > pot8) && ((alvo - pot8) > PASSO)) ? (pot8 + PASSO) : alvo;
  assign pot_desce = (pot8 > PASSO) ? (pot8 - PASSO) : 8'd0;
  assign pot_aprox = (pot8 <= alvo) ? pot_sobe :
                     (((pot8 - alvo) > PASSO) ? (pot8 - PASSO) : alvo);

  assign tick        = (cnt_tick == TW'(DIV_TICK - 1));
  assign subida      = sinc[1] & ~sinc[2];
  assign ok          = habilitado & ~erro;
  assign fim_demanda = ~demanda & (cont_on >= MIN_ON);

  assign estado              = est;
  assign umidificador_ligado = habilitado;

  always_ff @(posedge clock_geral or posedge reset) begin
    if (reset) begin
      est                 <= OCIOSO;
      cnt_tick            <= '0;
      sinc                <= '0;
      habilitado          <= 1'b0;
      demanda             <= 1'b0;
      erro                <= 1'b0;
      cont_on             <= '0;
      cont_off            <= MIN_OFF;
      pot_umidade         <= '0;
      umidificador_on_off <= 1'b0;
    end else begin
      cnt_tick <= tick ? '0 : (cnt_tick + TW'(1));

      // sinc[1:0] synchronize the button, sinc[2] keeps the previous level.
      sinc <= {sinc[1:0], botao_on_off};
      if (subida) habilitado <= ~habilitado;

      if (umidade_valida) begin
        if (media8 < lim_baixo)       demanda <= 1'b1;
        else if (media8 >= lim_alto)  demanda <= 1'b0;
      end

      erro <= (ajuste8 > POT_MAX) || (ref8 > POT_MAX);

      if (((est == SUBINDO) || (est == ATIVO)) && tick && (cont_on < MIN_ON))
        cont_on <= cont_on + 8'd1;

      case (est)
        OCIOSO: begin
          pot_umidade         <= '0;
          umidificador_on_off <= 1'b0;
          if (tick && (cont_off < MIN_OFF)) cont_off <= cont_off + 8'd1;
          if (ok && demanda && (cont_off == MIN_OFF)) begin
            est                 <= SUBINDO;
            cont_on             <= '0;
            umidificador_on_off <= 1'b1;
          end
        end
        SUBINDO: begin
          if (!ok || fim_demanda)  est <= DESCENDO;
          else if (pot8 == alvo)   est <= ATIVO;
          else if (tick)           pot_umidade <= 7'(pot_sobe);
        end
        ATIVO: begin
          if (!ok || fim_demanda)  est <= DESCENDO;
          else if (tick)           pot_umidade <= 7'(pot_aprox);
        end
        DESCENDO: begin
          // Renewed demand resumes the ramp without restarting the on-time.
          if (ok && demanda) begin
            est <= SUBINDO;
          end else if (pot_umidade == '0) begin
            est                 <= OCIOSO;
            cont_off            <= '0;
            umidificador_on_off <= 1'b0;
          end else if (tick) begin
            pot_umidade <= 7'(pot_desce);
          end
        end
        default: begin
          est                 <= OCIOSO;
          pot_umidade         <= '0;
          umidificador_on_off <= 1'b0;
        end
      endcase
    end
  end

endmodule
